// File: rtl/seqpu_bus_pkg.sv
// Shared types and default sizes for the seqpu memory bus.
package seqpu_bus_pkg;

  localparam int AW_DEF        = 16;
  localparam int DW_DEF        = 16;
  localparam int MAX_BURST_DEF = 8;

  typedef enum logic {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way combinational picker: sole requester wins, otherwise a locked
// owner under its burst cap keeps the port, else round-robin.
import seqpu_bus_pkg::*;

module mem_arb_pick (
  input  logic   req0,
  input  logic   req1,
  input  owner_t last_owner,
  input  logic   locked,
  input  logic   under_cap,
  output logic   gnt0,
  output logic   gnt1
);

  logic keep_s;

  // Grant decision for the current cycle.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    keep_s = locked && under_cap;
    case ({req0, req1})
      2'b10: gnt0 = 1'b1;
      2'b01: gnt1 = 1'b1;
      2'b11: begin
        // keep_s selects last_owner; otherwise the other requester gets its turn
        if ((last_owner == OWN0) == keep_s) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between the CPU
// (requester 0) and the loader (requester 1), with capped locked bursts.
import seqpu_bus_pkg::*;

module mem_arbiter #(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          lock0,
  input  logic          wren0_n,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          lock1,
  input  logic          wren1_n,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_out,
  output logic          mem_wren_n,
  input  logic [DW-1:0] mem_data_in
);

  localparam int BW = $clog2(MAX_BURST + 1);

  owner_t        last_owner_r;
  logic          locked_r;
  logic [BW-1:0] burst_cnt_r;
  logic          rvalid0_r;
  logic          rvalid1_r;

  logic          pick_gnt0_s;
  logic          pick_gnt1_s;
  logic          gnt0_s;
  logic          gnt1_s;
  logic          under_cap_s;
  owner_t        grant_own_s;

  assign under_cap_s = (burst_cnt_r < BW'(MAX_BURST));

  mem_arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner_r),
    .locked     (locked_r),
    .under_cap  (under_cap_s),
    .gnt0       (pick_gnt0_s),
    .gnt1       (pick_gnt1_s)
  );

  // Gate grants during reset and steer the owner's request onto the memory port.
  always_comb begin
    gnt0_s       = pick_gnt0_s & ~rst;
    gnt1_s       = pick_gnt1_s & ~rst;
    grant_own_s  = gnt1_s ? OWN1 : OWN0;
    mem_address  = {AW{1'b0}};
    mem_data_out = {DW{1'b0}};
    mem_wren_n   = 1'b1;
    if (gnt0_s) begin
      mem_address  = addr0;
      mem_data_out = wdata0;
      mem_wren_n   = wren0_n;
    end else if (gnt1_s) begin
      mem_address  = addr1;
      mem_data_out = wdata1;
      mem_wren_n   = wren1_n;
    end else begin
      mem_wren_n   = 1'b1;
    end
  end

  // Ownership history, burst counting and read-valid strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_r <= OWN1;
      locked_r     <= 1'b0;
      burst_cnt_r  <= {BW{1'b0}};
      rvalid0_r    <= 1'b0;
      rvalid1_r    <= 1'b0;
    end else begin
      rvalid0_r <= gnt0_s & wren0_n;
      rvalid1_r <= gnt1_s & wren1_n;
      if (gnt0_s || gnt1_s) begin
        last_owner_r <= grant_own_s;
        locked_r     <= gnt1_s ? lock1 : lock0;
        if (grant_own_s != last_owner_r) begin
          burst_cnt_r <= BW'(1);
        end else if (under_cap_s) begin
          burst_cnt_r <= burst_cnt_r + BW'(1);
        end else begin
          burst_cnt_r <= burst_cnt_r;
        end
      end else begin
        burst_cnt_r <= {BW{1'b0}};
        locked_r    <= 1'b0;
      end
    end
  end

  assign gnt0    = gnt0_s;
  assign gnt1    = gnt1_s;
  assign rvalid0 = rvalid0_r;
  assign rvalid1 = rvalid1_r;
  assign rdata0  = mem_data_in;
  assign rdata1  = mem_data_in;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single synchronous memory port of the seqpu between two requesters. Requester 0 is the CPU core; requester 1 is a loader/DMA engine. Each requester uses a req/gnt handshake. The block arbitrates round-robin, with optional locked bursts capped at a configurable length, and returns read data one cycle after issue on a per-requester rvalid strobe.

Parameters:
AW, 16, address width
DW, 16, data width
MAX_BURST, 8, maximum consecutive grants to a locked owner while the other requester waits (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req0  in  1  requester 0 transaction request
lock0  in  1  requester 0 wants to keep ownership for its next transaction
wren0_n  in  1  requester 0 write enable, active-low
addr0  in  AW  requester 0 address
wdata0  in  DW  requester 0 write data
gnt0  out  1  requester 0 transaction accepted this cycle
rvalid0  out  1  requester 0 read data valid
rdata0  out  DW  requester 0 read data
req1, lock1, wren1_n, addr1, wdata1, gnt1, rvalid1, rdata1  same as the requester 0 ports, for requester 1
mem_address  out  AW  memory address
mem_data_out  out  DW  memory write data
mem_wren_n  out  1  memory write enable, active-low
mem_data_in  in  DW  memory read data; valid one cycle after the address is presented

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - last_owner:=1, so requester 0 wins the first tie.
  - burst_cnt:=0.
  - rvalid0 and rvalid1 registered to 0.
  - Any read pending at reset is dropped; no rvalid follows.
- While rst=1, the combinational outputs are also forced: gnt0=gnt1=0, mem_wren_n=1, mem_address=0, mem_data_out=0.
- Grant is combinational in the same cycle as req; at most one of gnt0 and gnt1 is high.
- A granted transaction drives mem_address, mem_data_out and mem_wren_n from the owner's inputs in that same cycle.
- Throughput: one transaction per cycle, back-to-back.
- Idle cycle (no grant): mem_wren_n=1, mem_address=0, mem_data_out=0.
- Arbitration, evaluated each cycle:
  - Only one req high: grant it.
  - Both high, last_owner locked (lock of last_owner was high at its last grant) and burst_cnt<MAX_BURST: grant last_owner.
  - Both high otherwise: grant the requester that is not last_owner (round-robin).
- On each grant:
  - Same owner as last_owner: burst_cnt:=min(burst_cnt+1, MAX_BURST).
  - Different owner: burst_cnt:=1.
  - last_owner:=granted requester; the lock flag is registered from the granted lockX.
- Burst cap only applies when the other requester is waiting. A sole requester is granted indefinitely, and burst_cnt saturates.
- No-grant cycle: burst_cnt:=0 and the lock flag is cleared; last_owner holds.
- Reads (wrenX_n=1 at grant):
  - rvalidX is registered high exactly one cycle later.
  - rdataX=mem_data_in, combinational passthrough; meaningful only while rvalidX=1.
- Writes (wrenX_n=0): mem_wren_n=0 in the grant cycle; no rvalid is produced.
- A requester holds req, addr, wren_n, wdata and lock stable until it sees gnt. Deasserting req before gnt is legal and cancels the request.
- Simultaneous events:
  - An rvalid for a previous read and a new grant may coincide, including to the same requester.
  - A grant to one requester and an rvalid to the other may coincide.

Decomposition:
- Package seqpu_bus_pkg holds:
  - AW/DW defaults
  - owner_t, a 1-bit enum: OWN0, OWN1
  - MAX_BURST default
- Sub-module mem_arb_pick: a pure combinational 2-way picker. Inputs: req0, req1, last_owner, locked, burst_cnt<MAX_BURST. Outputs: gnt0, gnt1.
- mem_arbiter holds all registers: last_owner, lock flag, burst_cnt, rvalid.

Test Plan:
1. rst=1 for 2 cycles, both req high -> gnt0=gnt1=0, mem_wren_n=1, rvalid0=rvalid1=0. After release with both req high, the first grant goes to requester 0.
2. req0 read, addr0=0x0123, memory holds 0xBEEF:
   - same cycle: gnt0=1, mem_address=0x0123, mem_wren_n=1
   - next cycle: rvalid0=1, rdata0=0xBEEF, rvalid1=0
3. req0 and req1 held high, locks low, 6 cycles -> grant sequence 0,1,0,1,0,1; each read gives an rvalid to the matching requester one cycle later.
4. MAX_BURST=8, req0 with lock0 and req1 both held high for 12 cycles -> grants 0×8, then 1, then 0×3.
5. req1 write, addr1=0x0040, wdata1=0x5A5A, wren1_n=0 -> gnt1=1, mem_address=0x0040, mem_data_out=0x5A5A, mem_wren_n=0 in the same cycle; rvalid1 stays 0 next cycle.
6. Read granted to requester 0 at cycle N with rst=1 at the edge closing cycle N -> rvalid0=0 at N+1; normal grants resume after rst deasserts.
